// File: rtl/ycbcr_stream_ctrl_pkg.sv
// Shared types for the RGB->YCbCr stream controller: FSM states, the
// per-pixel tag that travels alongside the converter, and the word stored
// in the output FIFO.
package ycbcr_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Side-band information tracked through the converter latency.
    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    // One buffered output pixel with its frame markers.
    typedef struct packed {
        logic [7:0] luma;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       sof;
        logic       eol;
        logic       eof;
    } out_word_t;

    localparam int OUT_WORD_W = $bits(out_word_t);

    function automatic logic [7:0] rgb_red(input logic [23:0] rgb);
        return rgb[23:16];
    endfunction

    function automatic logic [7:0] rgb_green(input logic [23:0] rgb);
        return rgb[15:8];
    endfunction

    function automatic logic [7:0] rgb_blue(input logic [23:0] rgb);
        return rgb[7:0];
    endfunction

endpackage

// File: rtl/ycbcr_stream_ctrl_pix_sync_fifo.sv
// Small first-word-fall-through FIFO. The head entry is always visible on
// pop_data; push and pop may happen in the same cycle.
module pix_sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

    // Storage array: write-only port, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ycbcr_stream_ctrl.sv
// Frame sequencer around the RGB->YCbCr converter. Accepts RGB pixels,
// drives the converter, follows each pixel through the converter latency
// with a tag pipe and buffers the results for a valid/ready output with
// SOF/EOL/EOF markers. Acceptance is throttled by credits so the output
// FIFO can never overflow.
module ycbcr_stream_ctrl
    import ycbcr_stream_ctrl_pkg::*;
#(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int CONV_LAT   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_rgb,
    output logic [7:0]  red_ch,
    output logic [7:0]  green_ch,
    output logic [7:0]  blue_ch,
    input  logic [7:0]  luma_ch,
    input  logic [7:0]  cb_ch,
    input  logic [7:0]  cr_ch,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_ycbcr,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_eof
);
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NSTG = CONV_LAT + 1;
    localparam int CW   = $clog2(FIFO_DEPTH+1);
    localparam int OW   = CW + 1;

    state_t          state_reg;
    logic [XW-1:0]   x_reg;
    logic [YW-1:0]   y_reg;
    logic            busy_reg;
    logic            frame_done_reg;
    logic [7:0]      red_reg;
    logic [7:0]      green_reg;
    logic [7:0]      blue_reg;

    logic [NSTG-1:0] vld_vec;
    tag_t            tag_in;
    tag_t            tag_out;
    out_word_t       push_word;
    out_word_t       head_word;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [OW-1:0]   occupancy;
    logic            accept;
    logic            pop;
    logic            x_last;
    logic            y_last;

    assign x_last = (x_reg == XW'(IMG_W-1));
    assign y_last = (y_reg == YW'(IMG_H-1));

    // Pixels already committed: buffered plus still inside the converter.
    assign occupancy = OW'(fifo_count) + OW'($countones(vld_vec));
    assign s_ready   = (state_reg == ST_RUN) && (occupancy < OW'(FIFO_DEPTH));
    assign accept    = s_valid && s_ready;

    assign tag_in.vld = accept;
    assign tag_in.sof = accept && (x_reg == '0) && (y_reg == '0);
    assign tag_in.eol = accept && x_last;
    assign tag_in.eof = accept && x_last && y_last;

    // Tag pipe: one stage per converter cycle plus the input register stage,
    // so the last stage lines up with luma/cb/cr.
    generate
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_tag
            tag_t stage_reg;
            if (gi == 0) begin : g_first
                // First stage captures the tag of the pixel accepted this cycle.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= tag_in;
                    end
                end
            end else begin : g_rest
                // Later stages shift the tag forward one cycle.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_tag[gi-1].stage_reg;
                    end
                end
            end
            assign vld_vec[gi] = stage_reg.vld;
        end
    endgenerate

    assign tag_out = g_tag[NSTG-1].stage_reg;

    assign push_word.luma = luma_ch;
    assign push_word.cb   = cb_ch;
    assign push_word.cr   = cr_ch;
    assign push_word.sof  = tag_out.sof;
    assign push_word.eol  = tag_out.eol;
    assign push_word.eof  = tag_out.eof;

    pix_sync_fifo #(
        .WIDTH (OUT_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_out.vld),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    // Data and markers read as zero whenever nothing is offered.
    assign m_ycbcr = m_valid ? {head_word.luma, head_word.cb, head_word.cr} : 24'd0;
    assign m_sof   = m_valid && head_word.sof;
    assign m_eol   = m_valid && head_word.eol;
    assign m_eof   = m_valid && head_word.eof;

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign red_ch     = red_reg;
    assign green_ch   = green_reg;
    assign blue_ch    = blue_reg;

    // Frame FSM with raster counters and registered busy/frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_RUN;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (x_last) begin
                            x_reg <= '0;
                            if (y_last) begin
                                y_reg     <= '0;
                                state_reg <= ST_DRAIN;
                            end else begin
                                y_reg <= y_reg + 1'b1;
                            end
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_word.eof) begin
                        state_reg      <= ST_IDLE;
                        busy_reg       <= 1'b0;
                        frame_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Converter inputs load on accept and hold through bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_reg   <= '0;
            green_reg <= '0;
            blue_reg  <= '0;
        end else if (accept) begin
            red_reg   <= rgb_red(s_rgb);
            green_reg <= rgb_green(s_rgb);
            blue_reg  <= rgb_blue(s_rgb);
        end
    end

endmodule

// File: tb/tb_ycbcr_stream_ctrl.sv
// Bench for ycbcr_stream_ctrl on a 4x4 image with a pass-through converter
// stub (Y=R, Cb=G, Cr=B, CONV_LAT cycles). A scoreboard follows every
// accepted pixel to its output; directed sequences cover stalls, reset and
// start handling.
module tb_ycbcr_stream_ctrl;
    localparam int W     = 4;
    localparam int H     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int NPIX  = W * H;

    typedef struct {
        logic [23:0] rgb;
        logic [23:0] ycbcr;
        logic        sof;
        logic        eol;
        logic        eof;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_rgb;
    logic [7:0]  red_ch, green_ch, blue_ch;
    logic [7:0]  luma_ch, cb_ch, cr_ch;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [23:0] m_ycbcr;
    logic        m_sof, m_eol, m_eof;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int mr_mode;

    exp_t sb[$];
    exp_t obs[$];
    exp_t mon_e;
    int   acc_idx = 0;
    int   out_cnt = 0;
    int   max_out = 0;
    int   first_acc_cyc = 0;
    int   first_out_cyc = 0;
    int   eof_cyc = 0;
    int   fd_cyc = 0;
    logic [23:0] sof_data = 24'd0;

    vec_t vec [NPIX];

    ycbcr_stream_ctrl #(
        .IMG_W      (W),
        .IMG_H      (H),
        .CONV_LAT   (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_rgb      (s_rgb),
        .red_ch     (red_ch),
        .green_ch   (green_ch),
        .blue_ch    (blue_ch),
        .luma_ch    (luma_ch),
        .cb_ch      (cb_ch),
        .cr_ch      (cr_ch),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_ycbcr    (m_ycbcr),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Converter stub: pass-through delayed by LAT cycles after the *_ch registers.
    logic [23:0] conv_pipe [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) conv_pipe[k] <= 24'd0;
        end else begin
            conv_pipe[0] <= {red_ch, green_ch, blue_ch};
            for (int k = 1; k < LAT; k++) conv_pipe[k] <= conv_pipe[k-1];
        end
    end
    assign {luma_ch, cb_ch, cr_ch} = conv_pipe[LAT-1];

    // Downstream ready: 0 = stalled, 1 = always ready, 2 = random.
    always begin
        @(posedge clk);
        #1;
        case (mr_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(99) < 50);
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    endtask

    // Scoreboard: expectations are built from accepted inputs and raster position.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            acc_idx = 0;
        end else begin
            if (s_valid && s_ready) begin
                mon_e.d   = s_rgb;
                mon_e.sof = (acc_idx == 0);
                mon_e.eol = ((acc_idx % W) == W - 1);
                mon_e.eof = (acc_idx == NPIX - 1);
                sb.push_back(mon_e);
                if (acc_idx == 0) first_acc_cyc = cyc;
                acc_idx = (acc_idx + 1) % NPIX;
            end
            if (m_valid && m_ready) begin
                $display("OUT t=%0t ycbcr=%06h sof=%b eol=%b eof=%b", $time, m_ycbcr, m_sof, m_eol, m_eof);
                chk("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("sb_data", int'(m_ycbcr), int'(mon_e.d));
                    chk("sb_markers", int'({m_sof, m_eol, m_eof}), int'({mon_e.sof, mon_e.eol, mon_e.eof}));
                end
                mon_e.d = m_ycbcr; mon_e.sof = m_sof; mon_e.eol = m_eol; mon_e.eof = m_eof;
                obs.push_back(mon_e);
                if (m_sof) begin
                    first_out_cyc = cyc;
                    sof_data      = m_ycbcr;
                end
                if (m_eof) eof_cyc = cyc;
                out_cnt++;
            end
            if (sb.size() > max_out) max_out = sb.size();
            if (frame_done) fd_cyc = cyc;
        end
    end

    function automatic logic [23:0] pix(input int base, input int i);
        logic [7:0] b;
        b = 8'(base + i);
        return {b, b ^ 8'hA5, ~b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one pixel until it is accepted or the budget runs out.
    task automatic send_one(input logic [23:0] d, input int vpct, input int budget, output bit ok);
        int  g;
        bit  hs;
        g  = 0;
        hs = 1'b0;
        s_rgb = d;
        while (!hs && g < budget) begin
            s_valid = ($urandom_range(99) < vpct);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            g++;
        end
        s_valid = 1'b0;
        ok = hs;
    endtask

    task automatic send_range(input string nm, input int base, input int from, input int to,
                              input int vpct, input int budget);
        bit ok;
        for (int i = from; i < to; i++) begin
            send_one(pix(base, i), vpct, budget, ok);
            if (!ok) begin
                chk(nm, 0, 1);
                break;
            end
        end
    endtask

    // Returns at the falling edge where frame_done is seen.
    task automatic wait_done(input string nm, input int budget);
        bit seen;
        seen = 1'b0;
        for (int g = 0; g < budget && !seen; g++) begin
            @(negedge clk);
            seen = frame_done;
        end
        chk(nm, int'(seen), 1);
    endtask

    initial begin
        int  oc0;
        int  got;
        bit  ok;

        vec[0]  = '{24'h004080, 24'h004080, 1'b1, 1'b0, 1'b0};
        vec[1]  = '{24'h014181, 24'h014181, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{24'h024282, 24'h024282, 1'b0, 1'b0, 1'b0};
        vec[3]  = '{24'h034383, 24'h034383, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{24'h044484, 24'h044484, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{24'h054585, 24'h054585, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{24'h064686, 24'h064686, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{24'h074787, 24'h074787, 1'b0, 1'b1, 1'b0};
        vec[8]  = '{24'h084888, 24'h084888, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{24'h094989, 24'h094989, 1'b0, 1'b0, 1'b0};
        vec[10] = '{24'h0A4A8A, 24'h0A4A8A, 1'b0, 1'b0, 1'b0};
        vec[11] = '{24'h0B4B8B, 24'h0B4B8B, 1'b0, 1'b1, 1'b0};
        vec[12] = '{24'h0C4C8C, 24'h0C4C8C, 1'b0, 1'b0, 1'b0};
        vec[13] = '{24'h0D4D8D, 24'h0D4D8D, 1'b0, 1'b0, 1'b0};
        vec[14] = '{24'h0E4E8E, 24'h0E4E8E, 1'b0, 1'b0, 1'b0};
        vec[15] = '{24'h0F4F8F, 24'h0F4F8F, 1'b0, 1'b1, 1'b1};

        mr_mode = 1;
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_rgb   = 24'hFFFFFF;

        // 1. Reset state, then start with no input.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_ch", int'({red_ch, green_ch, blue_ch}), 0);
        chk("rst_m_data", int'({m_ycbcr, m_sof, m_eol, m_eof}), 0);
        rst = 1'b1;
        step();
        do_start();
        chk("start_busy", int'(busy), 1);
        chk("start_s_ready", int'(s_ready), 1);
        chk("start_m_valid", int'(m_valid), 0);

        // 2. Full-rate frame from the vector table.
        obs.delete();
        for (int i = 0; i < NPIX; i++) begin
            send_one(vec[i].rgb, 100, 20, ok);
            if (!ok) begin
                chk("t2_accept", 0, 1);
                break;
            end
        end
        wait_done("t2_frame_done", 100);
        chk("t2_busy_low", int'(busy), 0);
        step();
        chk("t2_out_count", obs.size(), NPIX);
        for (int i = 0; i < NPIX && i < obs.size(); i++) begin
            chk($sformatf("t2_data_%0d", i), int'(obs[i].d), int'(vec[i].ycbcr));
            chk($sformatf("t2_mark_%0d", i), int'({obs[i].sof, obs[i].eol, obs[i].eof}),
                int'({vec[i].sof, vec[i].eol, vec[i].eof}));
        end
        chk("t2_latency", first_out_cyc - first_acc_cyc, LAT + 2);
        chk("t2_contiguous", eof_cyc - first_out_cyc, NPIX - 1);
        chk("t2_done_timing", fd_cyc - eof_cyc, 1);

        // 3. Output stalled: credits stop acceptance at the FIFO depth.
        mr_mode = 0;
        do_start();
        oc0 = out_cnt;
        got = 0;
        for (int i = 0; i < NPIX; i++) begin
            send_one(pix(32, i), 100, 12, ok);
            if (!ok) break;
            got++;
        end
        chk("t3_accepts", got, DEPTH);
        chk("t3_s_ready_low", int'(s_ready), 0);
        chk("t3_m_valid", int'(m_valid), 1);
        chk("t3_head", int'(m_ycbcr), int'(pix(32, 0)));
        repeat (3) step();
        chk("t3_head_stable", int'({m_ycbcr, m_sof}), int'({pix(32, 0), 1'b1}));
        mr_mode = 1;
        send_range("t3_resume", 32, got, NPIX, 100, 40);
        wait_done("t3_frame_done", 100);
        chk("t3_out_count", out_cnt - oc0, NPIX);

        // 4. Random valid/ready over three frames.
        mr_mode = 2;
        for (int f = 0; f < 3; f++) begin
            do_start();
            oc0 = out_cnt;
            send_range("t4_accept", 64 + 16 * f, 0, NPIX, 60, 80);
            wait_done("t4_frame_done", 400);
            chk("t4_out_count", out_cnt - oc0, NPIX);
        end

        // 5. Reset mid-frame after three accepts, then a fresh frame.
        mr_mode = 1;
        step();
        do_start();
        send_range("t5_accept", 96, 0, 3, 100, 20);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_clear", int'({s_ready, m_valid, busy, frame_done, red_ch, green_ch, blue_ch}), 0);
        chk("t5_async_m", int'({m_ycbcr, m_sof, m_eol, m_eof}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        do_start();
        oc0 = out_cnt;
        send_range("t5_accept2", 144, 0, NPIX, 100, 20);
        wait_done("t5_frame_done", 100);
        chk("t5_sof_pixel", int'(sof_data), int'(pix(144, 0)));
        chk("t5_out_count", out_cnt - oc0, NPIX);

        // 6. start ignored in RUN/DRAIN; start right after frame_done works.
        step();
        do_start();
        oc0 = out_cnt;
        send_range("t6_accept", 176, 0, 5, 100, 20);
        start = 1'b1;
        send_range("t6_accept", 176, 5, 6, 100, 20);
        start = 1'b0;
        send_range("t6_accept", 176, 6, NPIX, 100, 20);
        chk("t6_busy_drain", int'(busy), 1);
        do_start();
        chk("t6_still_busy", int'(busy), 1);
        wait_done("t6_frame_done", 100);
        chk("t6_out_count", out_cnt - oc0, NPIX);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6_restart_busy", int'(busy), 1);
        chk("t6_restart_ready", int'(s_ready), 1);
        oc0 = out_cnt;
        send_range("t6_accept2", 208, 0, NPIX, 100, 20);
        wait_done("t6_frame_done2", 100);
        chk("t6_out_count2", out_cnt - oc0, NPIX);

        step();
        chk("end_sb_empty", sb.size(), 0);
        chk("max_outstanding", max_out, DEPTH);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
